// File: rtl/act_pkg.sv
// Shared definitions for the activation loader: FSM encoding and default sizing.
package act_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } act_state_t;

    localparam int ACT_DATA_W   = 8;
    localparam int ACT_ADDR_W   = 16;
    localparam int ACT_TILE_LEN = 9;
    localparam int ACT_IDX_W    = 4;
    localparam int ACT_RD_LAT   = 2;

endpackage

// File: rtl/activate_loader_if.sv
// Controller / BRAM / core facing signals of the activation loader.
// ACT_LOADER_ZERO_PAD_EN adds the pad_mask input.
interface activate_loader_if
    import act_pkg::*;
#(
    parameter int DATA_W   = ACT_DATA_W,
    parameter int ADDR_W   = ACT_ADDR_W,
    parameter int TILE_LEN = ACT_TILE_LEN,
    parameter int IDX_W    = ACT_IDX_W
);
    logic              start_load;
    logic              start_core;
    logic [ADDR_W-1:0] base_addr;
`ifdef ACT_LOADER_ZERO_PAD_EN
    logic [TILE_LEN-1:0] pad_mask;
`endif
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
    logic [IDX_W-1:0]  act_rd_idx;
    logic [DATA_W-1:0] act_rd_data;
    logic              activate_ready;
    logic              busy;
    logic              load_drop;

    modport slave (
`ifdef ACT_LOADER_ZERO_PAD_EN
        input  pad_mask,
`endif
        input  start_load, start_core, base_addr, mem_rd_data, act_rd_idx,
        output mem_rd_en, mem_addr, act_rd_data, activate_ready, busy, load_drop
    );

    modport master (
`ifdef ACT_LOADER_ZERO_PAD_EN
        output pad_mask,
`endif
        output start_load, start_core, base_addr, mem_rd_data, act_rd_idx,
        input  mem_rd_en, mem_addr, act_rd_data, activate_ready, busy, load_drop
    );
endinterface

// File: rtl/act_pingpong_buf.sv
// Two-bank tile buffer: one synchronous write port, one combinational read port.
module act_pingpong_buf
    import act_pkg::*;
#(
    parameter int DATA_W   = ACT_DATA_W,
    parameter int TILE_LEN = ACT_TILE_LEN,
    parameter int IDX_W    = ACT_IDX_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_LEN - 1);

    logic [DATA_W-1:0] mem [2][TILE_LEN];

    always_ff @(posedge clk) begin
        if (we && wr_idx <= LAST_IDX) begin
            mem[wr_bank][wr_idx] <= wr_data;
        end
    end

    // Indices past the tile read as zero rather than X.
    assign rd_data = (rd_idx <= LAST_IDX) ? mem[rd_bank][rd_idx] : '0;
endmodule

// File: rtl/activate_loader.sv
// Fetches one activation tile from BRAM into a ping-pong buffer per start_load.
// ACT_LOADER_ZERO_PAD_EN: pad_mask slots skip the BRAM read and store zero.
//
// state    | meaning
// ST_IDLE  | waiting for start_load
// ST_ISSUE | one BRAM read slot per cycle, TILE_LEN slots
// ST_DRAIN | waiting for the last read return to be written
// ST_DONE  | one-cycle activate_ready, write bank becomes the full bank
module activate_loader
    import act_pkg::*;
#(
    parameter int DATA_W   = ACT_DATA_W,
    parameter int ADDR_W   = ACT_ADDR_W,
    parameter int TILE_LEN = ACT_TILE_LEN,
    parameter int IDX_W    = ACT_IDX_W,
    parameter int RD_LAT   = ACT_RD_LAT
) (
    input logic         clk,
    input logic         rst,
    activate_loader_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TILE_LEN - 1);

    act_state_t        state, state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [IDX_W-1:0]  issue_idx;
    logic              wr_bank, full_bank, rd_bank, load_drop_q;
    logic              accept, issue_pad, ret_last;
    logic [RD_LAT-1:0] ret_v, ret_pad;
    logic [IDX_W-1:0]  ret_idx [RD_LAT];

`ifdef ACT_LOADER_ZERO_PAD_EN
    logic [TILE_LEN-1:0] pad_q;
    assign issue_pad = pad_q[issue_idx];
`else
    assign issue_pad = 1'b0;
`endif

    assign accept   = bus.start_load && (state == ST_IDLE || state == ST_DONE);
    assign ret_last = ret_v[RD_LAT-1] && (ret_idx[RD_LAT-1] == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (bus.start_load) state_nx = ST_ISSUE;
            ST_ISSUE: if (issue_idx == LAST_IDX) state_nx = ST_DRAIN;
            ST_DRAIN: if (ret_last) state_nx = ST_DONE;
            ST_DONE:  state_nx = bus.start_load ? ST_ISSUE : ST_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_rd_en      = 1'b0;
        bus.mem_addr       = '0;
        bus.activate_ready = 1'b0;
        bus.busy           = 1'b0;
        unique case (state)
            ST_ISSUE: begin
                bus.mem_rd_en = ~issue_pad;
                bus.mem_addr  = base_q + {{(ADDR_W-IDX_W){1'b0}}, issue_idx};
                bus.busy      = 1'b1;
            end
            ST_DRAIN: bus.busy = 1'b1;
            ST_DONE:  bus.activate_ready = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            issue_idx   <= '0;
            wr_bank     <= 1'b0;
            full_bank   <= 1'b1;
            rd_bank     <= 1'b0;
            load_drop_q <= 1'b0;
            ret_v       <= '0;
        end else begin
            if (accept) begin
                base_q    <= bus.base_addr;
                issue_idx <= '0;
                // In DONE the full bank flips to wr_bank on this same edge.
                wr_bank   <= (state == ST_DONE) ? ~wr_bank : ~full_bank;
            end else if (state == ST_ISSUE) begin
                issue_idx <= issue_idx + 1'b1;
            end
            if (state == ST_DONE) full_bank <= wr_bank;
            if (bus.start_core) rd_bank <= (state == ST_DONE) ? wr_bank : full_bank;
            if (bus.start_load && (state == ST_ISSUE || state == ST_DRAIN)) load_drop_q <= 1'b1;
            ret_v[0] <= (state == ST_ISSUE);
            for (int k = 1; k < RD_LAT; k++) ret_v[k] <= ret_v[k-1];
        end
    end

    always_ff @(posedge clk) begin
`ifdef ACT_LOADER_ZERO_PAD_EN
        if (accept) pad_q <= bus.pad_mask;
`endif
        ret_idx[0] <= issue_idx;
        ret_pad[0] <= issue_pad;
        for (int k = 1; k < RD_LAT; k++) begin
            ret_idx[k] <= ret_idx[k-1];
            ret_pad[k] <= ret_pad[k-1];
        end
    end

    assign bus.load_drop = load_drop_q;

    act_pingpong_buf #(
        .DATA_W   (DATA_W),
        .TILE_LEN (TILE_LEN),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk     (clk),
        .we      (ret_v[RD_LAT-1]),
        .wr_bank (wr_bank),
        .wr_idx  (ret_idx[RD_LAT-1]),
        .wr_data (ret_pad[RD_LAT-1] ? '0 : bus.mem_rd_data),
        .rd_bank (rd_bank),
        .rd_idx  (bus.act_rd_idx),
        .rd_data (bus.act_rd_data)
    );
endmodule

// File: tb/tb_activate_loader.sv
// Scoreboard bench for activate_loader: expected reads, ready pulses and probes
// are queued by the stimulus and consumed by a negedge monitor.
module tb_activate_loader;
    import act_pkg::*;

    localparam int DW = 8;
    localparam int AW = 16;
    localparam int TL = 9;
    localparam int IW = 4;
    localparam int RL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    activate_loader_if #(.DATA_W(DW), .ADDR_W(AW), .TILE_LEN(TL), .IDX_W(IW)) bus();

    activate_loader #(
        .DATA_W(DW), .ADDR_W(AW), .TILE_LEN(TL), .IDX_W(IW), .RD_LAT(RL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: data = addr[7:0], two-cycle latency; idle returns 0xEE.
    logic [DW-1:0] d1, d2;
    always @(posedge clk) begin
        d1 <= bus.mem_rd_en ? bus.mem_addr[7:0] : 8'hEE;
        d2 <= d1;
    end
    assign bus.mem_rd_data = d2;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } rd_exp_t;

    typedef enum {K_DATA, K_DROP, K_STAT, K_EMPTY} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
        string       name;
    } probe_t;

    rd_exp_t rd_q[$];
    int      rdy_q[$];
    probe_t  pr_q[$];
    logic    probe_v = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always @(negedge clk) begin
        rd_exp_t     r;
        probe_t      p;
        int          rc;
        logic [31:0] obs;
        if (bus.mem_rd_en) begin
            n_total++;
            if (rd_q.size() == 0) begin
                $display("FAIL extra_read: got addr %h at cycle %0d, required no read", bus.mem_addr, cyc);
            end else begin
                r = rd_q.pop_front();
                if (r.cyc == cyc && r.addr == bus.mem_addr) n_pass++;
                else $display("FAIL rd_issue: got addr %h at cycle %0d, required addr %h at cycle %0d",
                              bus.mem_addr, cyc, r.addr, r.cyc);
            end
        end
        if (bus.activate_ready) begin
            n_total++;
            if (rdy_q.size() == 0) begin
                $display("FAIL extra_ready: got activate_ready at cycle %0d, required none", cyc);
            end else begin
                rc = rdy_q.pop_front();
                if (rc == cyc) n_pass++;
                else $display("FAIL ready_time: got activate_ready at cycle %0d, required cycle %0d", cyc, rc);
            end
        end
        if (probe_v && pr_q.size() != 0) begin
            p = pr_q.pop_front();
            case (p.kind)
                K_DATA:  obs = {24'b0, bus.act_rd_data};
                K_DROP:  obs = {31'b0, bus.load_drop};
                K_STAT:  obs = {12'b0, bus.busy, bus.activate_ready, bus.load_drop, bus.mem_rd_en, bus.mem_addr};
                default: obs = rd_q.size() + rdy_q.size();
            endcase
            n_total++;
            if (obs === p.exp) n_pass++;
            else $display("FAIL %s: got %h, required %h", p.name, obs, p.exp);
        end
    end

    task automatic probe(input kind_t k, input logic [31:0] e, input string nm);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        p.name = nm;
        pr_q.push_back(p);
        probe_v = 1'b1;
        @(posedge clk); #1;
        probe_v = 1'b0;
    endtask

    task automatic data_chk(input logic [IW-1:0] idx, input logic [DW-1:0] e, input string nm);
        bus.act_rd_idx = idx;
        probe(K_DATA, {24'b0, e}, nm);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic core_pulse();
        bus.start_core = 1'b1;
        @(posedge clk); #1;
        bus.start_core = 1'b0;
    endtask

    // Issues start_load in the current cycle; t is the cycle of the first read slot.
    task automatic load(input logic [AW-1:0] base, input logic [TL-1:0] mask,
                        input bit core, input bit push_rdy, output int t);
        rd_exp_t r;
        t = cyc + 1;
        bus.start_load = 1'b1;
        bus.base_addr  = base;
        bus.start_core = core;
`ifdef ACT_LOADER_ZERO_PAD_EN
        bus.pad_mask   = mask;
`endif
        for (int s = 0; s < TL; s++) begin
            if (!mask[s]) begin
                r.cyc  = t + s;
                r.addr = base + AW'(s);
                rd_q.push_back(r);
            end
        end
        if (push_rdy) rdy_q.push_back(t + TL + RL);
        @(posedge clk); #1;
        bus.start_load = 1'b0;
        bus.start_core = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int t, td, te;
        bus.start_load = 1'b0;
        bus.start_core = 1'b0;
        bus.base_addr  = '0;
        bus.act_rd_idx = '0;
`ifdef ACT_LOADER_ZERO_PAD_EN
        bus.pad_mask   = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        probe(K_STAT, 32'h0, "reset_held");
        rst = 1'b0;
        probe(K_STAT, 32'h0, "reset_state");

        // Single load into bank 0.
        load(16'h0100, '0, 1'b0, 1'b1, t);
        wait_until(t + 12);
        core_pulse();
        data_chk(4'd4, 8'h04, "a_idx4");
        data_chk(4'd0, 8'h00, "a_idx0");
        data_chk(4'd8, 8'h08, "a_idx8");

        // Ping-pong: load into bank 1 while the core keeps reading bank 0.
        load(16'h0200, '0, 1'b1, 1'b1, t);
        data_chk(4'd3, 8'h03, "b_core_idx3");
        wait_until(t + 6);
        data_chk(4'd7, 8'h07, "b_core_idx7");
        wait_until(t + 12);
        data_chk(4'd0, 8'h00, "b_pre_swap");
        core_pulse();
        data_chk(4'd0, 8'h00, "b_idx0");
        data_chk(4'd5, 8'h05, "b_idx5");

        // Dropped request mid-load.
        load(16'h0340, '0, 1'b0, 1'b1, t);
        wait_until(t + 4);
        bus.start_load = 1'b1;
        bus.base_addr  = 16'h0999;
        @(posedge clk); #1;
        bus.start_load = 1'b0;
        probe(K_DROP, 32'h1, "drop_set");
        wait_until(t + 12);
        data_chk(4'd2, 8'h02, "c_old_bank");
        core_pulse();
        data_chk(4'd2, 8'h42, "c_idx2");
        probe(K_DROP, 32'h1, "drop_sticky");

        // Back-to-back: second request lands in the DONE cycle.
        load(16'h0050, '0, 1'b0, 1'b1, td);
        wait_until(td + TL + RL);
        load(16'h0060, '0, 1'b0, 1'b1, te);
        core_pulse();
        data_chk(4'd1, 8'h51, "d_bank");
        wait_until(te + 12);
        core_pulse();
        data_chk(4'd1, 8'h61, "e_bank");

        // Address wrap, then reset during DRAIN: no ready may follow.
        load(16'hFFFC, '0, 1'b0, 1'b0, t);
        wait_until(t + 9);
        rst = 1'b1;
        @(posedge clk); #1;
        probe(K_STAT, 32'h0, "reset_mid_load");
        rst = 1'b0;
        wait_until(t + 18);
        probe(K_STAT, 32'h0, "post_reset_idle");

`ifdef ACT_LOADER_ZERO_PAD_EN
        load(16'h0070, 9'b100000001, 1'b0, 1'b1, t);
        wait_until(t + 12);
        core_pulse();
        data_chk(4'd0, 8'h00, "pad_idx0");
        data_chk(4'd8, 8'h00, "pad_idx8");
        data_chk(4'd1, 8'h71, "pad_idx1");
`endif

        probe(K_EMPTY, 32'h0, "scoreboard_drained");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/activate_loader.md
Name: activate_loader

Overview:
Responder side of the activation-load handshake. On a start_load pulse it fetches one TILE_LEN-word activation tile from activation BRAM into a ping-pong buffer, then pulses activate_ready. The core reads the most recently completed bank while the next tile loads into the other bank; banks swap on start_core. It sits between the activation BRAM and the MAC core, driven by the pipeline controller.

Parameters:
DATA_W, 8, activation word width
ADDR_W, 16, BRAM address width
TILE_LEN, 9, words per tile (3x3 window); must be >= 1
IDX_W, 4, index width; must satisfy 2^IDX_W >= TILE_LEN
RD_LAT, 2, fixed BRAM read latency in cycles; must be >= 1

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
start_load  in  1  one-cycle load request from the pipeline controller
start_core  in  1  core start pulse; swaps the read bank
base_addr  in  ADDR_W  tile base address, sampled with an accepted start_load
mem_rd_en  out  1  BRAM read enable
mem_addr  out  ADDR_W  BRAM read address
mem_rd_data  in  DATA_W  BRAM data, valid RD_LAT cycles after mem_rd_en
act_rd_idx  in  IDX_W  core read index
act_rd_data  out  DATA_W  word act_rd_idx of the read bank, combinational
activate_ready  out  1  one-cycle pulse: tile fully written
busy  out  1  high while a load is in progress (ISSUE or DRAIN)
load_drop  out  1  sticky: a start_load arrived while busy

Behaviour:
- Reset values: mem_rd_en=0, mem_addr=0, activate_ready=0, busy=0, load_drop=0, state=IDLE, wr_bank=0, full_bank=1, rd_bank=0. Buffer contents are not cleared.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE or DONE with start_load=1: latch base_addr, set wr_bank <= ~full_bank, issue count i <= 0, go to ISSUE.
- DONE without start_load: go to IDLE. DONE lasts exactly one cycle, so back-to-back loads are accepted.
- ISSUE: mem_rd_en=1, mem_addr=base+i (modulo 2^ADDR_W wrap), i++ each cycle. After TILE_LEN issues, go to DRAIN.
- Return tracking: an RD_LAT-deep valid/index shift register follows each issue. When an entry emerges, mem_rd_data is written into buffer[wr_bank][idx] on that clock edge.
- DRAIN: once the last write has occurred, go to DONE.
- DONE: activate_ready=1 for exactly one cycle; full_bank <= wr_bank in the same cycle.
- Latency: start_load sampled at edge T gives mem_rd_en in cycles T+1..T+TILE_LEN, and activate_ready in cycle T+TILE_LEN+RD_LAT+1.
- start_load in ISSUE or DRAIN: ignored and sets load_drop, which stays set until reset. The in-flight load is unaffected.
- start_core=1 (any state): rd_bank <= full_bank. If start_core and the DONE cycle coincide, rd_bank takes the new full_bank value, which is the bank just completed.
- start_load and start_core in the same cycle, the normal pipelining case: the new load writes ~full_bank while the core reads full_bank. There is no collision.
- Reset mid-load: aborts immediately. No activate_ready is issued, and pending returns are discarded.

Optional Feature:
Macro ACT_LOADER_ZERO_PAD_EN.
- With the macro: adds input port pad_mask (TILE_LEN bits), sampled with start_load. For each i with pad_mask[i]=1, mem_rd_en stays 0 in that issue slot but the slot is still consumed, and buffer[wr_bank][i] is written as 0 at the slot's return time. Timing is identical to the unpadded case.
- Without the macro: port absent; every slot reads BRAM.

Decomposition:
- Shared package act_pkg: FSM state encoding (ST_IDLE=0, ST_ISSUE=1, ST_DRAIN=2, ST_DONE=3) and the default DATA_W/TILE_LEN/RD_LAT constants.
- One sub-module, act_pingpong_buf. It holds 2 x TILE_LEN x DATA_W registers with one synchronous write port (bank, idx, data, we) and one combinational read port (bank, idx).

Test Plan:
- Single load: rst released, base_addr=0x0100, start_load at T with memory model data=addr[7:0] and RD_LAT=2. Expect mem_addr 0x0100..0x0108 in T+1..T+9, activate_ready only at T+12, then start_core; act_rd_idx=4 returns 0x04.
- Ping-pong: second load at base 0x0200 concurrent with start_core. Expect the core to read bank 0 data (0x00..0x08) unchanged throughout. After the next start_core, idx 0 reads 0x00 from bank 1 (addr 0x0200).
- Drop: start_load at T+5 of an active load. Expect load_drop=1 persisting, exactly one activate_ready at T+12, and no extra reads.
- Back-to-back: start_load during the DONE cycle. Expect the next ISSUE to start the following cycle, the second activate_ready 10+RD_LAT cycles later, and bank alternation.
- Wrap and reset: base_addr=0xFFFC. Expect addresses 0xFFFC..0xFFFF then 0x0000..0x0004. Assert rst during DRAIN: expect no activate_ready and all outputs at reset values the next cycle.
- With ACT_LOADER_ZERO_PAD_EN: pad_mask=9'b100000001. Expect mem_rd_en low in slots 0 and 8, buffer idx 0 and 8 reading 0, and the activate_ready cycle unchanged.
